// File: rtl/mult_datapath.sv
// mult_datapath: X:A:B register datapath for an 8x8 signed shift-add multiplier.
// The external controller sequences LoadB/goToB/Add/Sub/Shift; this block only
// holds the X (sign extension), A (upper byte) and B (multiplier/lower byte) state.
// Optional build macro MULT_SHIFTCNT_EN adds a saturating shift counter that drives Done;
// without it Done is tied low and no counter is built.
module mult_datapath (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       LoadB,
    input  logic       goToB,
    input  logic       Add,
    input  logic       Sub,
    input  logic       Shift,
    input  logic [7:0] Switches,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       M,
    output logic       Done
);

    logic       x_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [8:0] add_res;
    logic [8:0] sub_res;
    logic       do_shift;

    // 9-bit sign-extended sum/difference; the carry out of bit 8 is simply dropped
    always_comb begin
        add_res = {a_q[7], a_q} + {Switches[7], Switches};
        sub_res = {a_q[7], a_q} - {Switches[7], Switches};
    end

    // Shift takes effect only when no higher-priority control is asserted
    assign do_shift = Shift & ~LoadB & ~goToB & ~Sub & ~Add;

    // Datapath registers, one action per cycle in priority LoadB > goToB > Sub > Add > Shift
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q <= 1'b0;
            a_q <= 8'h00;
            b_q <= 8'h00;
        end else if (LoadB) begin
            x_q <= 1'b0;
            a_q <= 8'h00;
            b_q <= Switches;
        end else if (goToB) begin
            x_q <= 1'b0;
            a_q <= 8'h00;
        end else if (Sub) begin
            if (b_q[0]) {x_q, a_q} <= sub_res;
        end else if (Add) begin
            if (b_q[0]) {x_q, a_q} <= add_res;
        end else if (Shift) begin
            a_q <= {x_q, a_q[7:1]};
            b_q <= {a_q[0], b_q[7:1]};
        end
    end

`ifdef MULT_SHIFTCNT_EN
    logic [3:0] cnt_q;

    // Shift counter: cleared at the start of a multiply, saturates at 8
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= 4'd0;
        end else if (LoadB || goToB) begin
            cnt_q <= 4'd0;
        end else if (do_shift && (cnt_q != 4'd8)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign Done = (cnt_q == 4'd8);
`else
    logic unused_shift;
    assign unused_shift = do_shift;
    assign Done = 1'b0;
`endif

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign M    = b_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed and randomized checks of mult_datapath against
// plain signed arithmetic for the full 17-cycle multiply sequence.
module tb_mult_datapath;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       LoadB, goToB, Add, Sub, Shift;
    logic [7:0] Switches;
    logic [7:0] Aval, Bval;
    logic       X, M, Done;

    int n_vec = 0;
    int n_err = 0;

`ifdef MULT_SHIFTCNT_EN
    localparam logic CNT_EN = 1'b1;
`else
    localparam logic CNT_EN = 1'b0;
`endif

    mult_datapath dut (
        .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .goToB(goToB), .Add(Add),
        .Sub(Sub), .Shift(Shift), .Switches(Switches), .Aval(Aval), .Bval(Bval),
        .X(X), .M(M), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with the given controls; outputs sampled 1 time unit after the edge
    task automatic step(input logic ld, input logic gt, input logic ad, input logic sb, input logic sh);
        LoadB = ld; goToB = gt; Add = ad; Sub = sb; Shift = sh;
        @(posedge Clk);
        #1;
        LoadB = 0; goToB = 0; Add = 0; Sub = 0; Shift = 0;
    endtask

    task automatic load_b(input logic [7:0] v);
        Switches = v;
        step(1, 0, 0, 0, 0);
    endtask

    // Controller sequence: goToB, 7x[Add,Shift], Add+Sub, Shift
    task automatic run_seq(input logic [7:0] s);
        Switches = s;
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 1);
        end
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);
    endtask

    // Load b0, multiply by s, compare against integer product
    task automatic mult_check(input string tag, input logic [7:0] b0, input logic [7:0] s);
        int          p;
        logic [15:0] pv;
        p  = $signed(b0) * $signed(s);
        pv = p[15:0];
        load_b(b0);
        run_seq(s);
        check({tag, "_prod"}, {Aval, Bval}, pv);
        check({tag, "_x"}, {15'd0, X}, {15'd0, pv[15]});
        check({tag, "_done"}, {15'd0, Done}, {15'd0, CNT_EN});
    endtask

    initial begin
        LoadB = 0; goToB = 0; Add = 0; Sub = 0; Shift = 0; Switches = 8'h00;
        Reset = 1;
        #2;
        check("reset_state", {Aval, Bval}, 16'h0000);
        check("reset_xmd", {13'd0, X, M, Done}, 16'h0000);
        @(posedge Clk); #1;
        Reset = 0;

        // Known product cases, plus exact expected bytes
        mult_check("b3_s7", 8'h03, 8'h07);
        check("b3_s7_bytes", {Aval, Bval}, 16'h0015);
        mult_check("b3_sm2", 8'h03, 8'hFE);
        check("b3_sm2_bytes", {7'd0, X, Aval}, {7'd0, 1'b1, 8'hFF});
        mult_check("bm3_s7", 8'hFD, 8'h07);
        check("bm3_s7_bytes", {Aval, Bval}, 16'hFFEB);
        mult_check("extreme_neg", 8'h80, 8'h80);
        mult_check("mixed_ext", 8'h7F, 8'h80);
        mult_check("zero_b", 8'h00, 8'h9C);

        // Add of 0x80 into zero A with M=1, then shift sign-fills
        load_b(8'h01);
        check("m_after_load", {15'd0, M}, 16'd1);
        Switches = 8'h80;
        step(0, 0, 1, 0, 0);
        check("add80", {7'd0, X, Aval}, {7'd0, 1'b1, 8'h80});
        step(0, 0, 0, 0, 1);
        check("shift_sign", {6'd0, X, M, Aval}, {6'd0, 1'b1, 1'b0, 8'hC0});
        check("shift_b", {8'd0, Bval}, 16'h0000);

        // M=0: Add and Sub both hold
        Switches = 8'h11;
        step(0, 0, 1, 0, 0);
        check("add_m0_hold", {7'd0, X, Aval}, {7'd0, 1'b1, 8'hC0});
        step(0, 0, 1, 1, 0);
        check("sub_m0_hold", {7'd0, X, Aval}, {7'd0, 1'b1, 8'hC0});
        step(0, 0, 0, 0, 0);
        check("idle_hold", {7'd0, X, Aval}, {7'd0, 1'b1, 8'hC0});

        // LoadB overrides Add
        Switches = 8'h55;
        step(1, 0, 1, 0, 0);
        check("loadb_prio", {Aval, Bval}, 16'h0055);
        check("loadb_prio_x", {15'd0, X}, 16'd0);

        // Sub overrides Add with M=1: 0 - 5 = -5
        Switches = 8'h05;
        step(0, 0, 1, 1, 0);
        check("sub_prio", {7'd0, X, Aval}, {7'd0, 1'b1, 8'hFB});
        // goToB clears X:A, keeps B
        step(0, 1, 0, 0, 0);
        check("gotob", {7'd0, X, Aval}, {7'd0, 1'b0, 8'h00});
        check("gotob_b", {8'd0, Bval}, 16'h0055);

        // Asynchronous reset mid-sequence
        load_b(8'hF0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        check("pre_reset_b", {8'd0, Bval}, 16'h000F);
        #2;
        Reset = 1;
        #1;
        check("async_reset", {5'd0, X, M, Done, Bval}, 16'h0000);
        Switches = 8'hAA;
        step(1, 0, 0, 0, 0);
        check("reset_held", {Aval, Bval}, 16'h0000);
        Reset = 0;
        load_b(8'h81);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
        check("done_after7", {15'd0, Done}, 16'd0);
        step(0, 0, 0, 0, 1);
        check("done_after8", {15'd0, Done}, {15'd0, CNT_EN});
        check("b_after8", {8'd0, Bval}, 16'h0000);
        step(0, 0, 0, 0, 1);
        check("done_sat", {15'd0, Done}, {15'd0, CNT_EN});

        // Randomized products against integer multiplication
        for (int t = 0; t < 24; t++) begin
            logic [7:0] rb, rs;
            rb = 8'($urandom);
            rs = 8'($urandom);
            mult_check("rand", rb, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
